// File: rtl/store_buffer.sv
// Store buffer between a single-issue core and data memory.
// Accepted stores sit in a circular FIFO and drain to memory one per cycle,
// oldest first. A store to the same word as the youngest entry merges into
// it. Loads see buffered data through a youngest-first forwarding path.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Empty,
    output logic        MemWe,
    output logic [31:0] MemAdr,
    output logic [31:0] MemWData,
    input  logic        MemReady,
    output logic [31:0] MemRAdr,
    input  logic [31:0] MemRData
);

    localparam int         PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    // Entry storage: word address and data per slot.
    logic [29:0]   adr_q [DEPTH];
    logic [31:0]   dat_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic [PW-1:0] young;
    logic [PW-1:0] fwd_idx;
    logic          nonempty;
    logic          drain;
    logic          coalesce;
    logic          alloc;

    // Byte offset within a word plays no part in matching or draining.
    logic          unused_adr_bits;
    assign unused_adr_bits = ^DataAdr[1:0];

    // Store acceptance decisions and drain-side outputs.
    always_comb begin
        young    = tail_q - PW'(1);
        nonempty = (count_q != '0);
        drain    = nonempty & MemReady;
        // The youngest entry may only absorb a store if it is not leaving this cycle.
        coalesce = MemWrite & nonempty & (adr_q[young] == DataAdr[31:2])
                   & ~((count_q == (PW+1)'(1)) & drain);
        alloc    = MemWrite & ~coalesce & (count_q != FULL);
        // A same-cycle drain does not free room for the stalled store.
        Stall    = MemWrite & (count_q == FULL) & ~coalesce;
        Empty    = ~nonempty;
        MemWe    = nonempty;
        MemAdr   = nonempty ? {adr_q[head_q], 2'b00} : '0;
        MemWData = nonempty ? dat_q[head_q] : '0;
        MemRAdr  = DataAdr;
    end

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = alloc ? tail_q + PW'(1) : tail_q;
        count_d = count_q + (PW+1)'(alloc) - (PW+1)'(drain);
    end

    // Load forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        ReadData = MemRData;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) && (adr_q[fwd_idx] == DataAdr[31:2]))
                ReadData = dat_q[fwd_idx];
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload writes on allocate or coalesce.
    // NOTE: the entry array has no reset; count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (alloc) begin
                adr_q[tail_q] <= DataAdr[31:2];
                dat_q[tail_q] <= WriteData;
            end
            if (coalesce)
                dat_q[young] <= WriteData;
        end
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered stores; power of two, at least 2.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port: clk  in  1  rising-edge clock for all state.
REQ-004 Port: reset  in  1  synchronous reset, active-high.
REQ-005 Port: MemWrite  in  1  core store request this cycle.
REQ-006 Port: DataAdr  in  32  core load/store byte address (word-aligned use; bits [1:0] ignored).
REQ-007 Port: WriteData  in  32  core store data.
REQ-008 Port: ReadData  out  32  load data returned to core (combinational).
REQ-009 Port: Stall  out  1  store not accepted this cycle; core holds its request.
REQ-010 Port: Empty  out  1  buffer holds no entries.
REQ-011 Port: MemWe  out  1  drain request to data memory.
REQ-012 Port: MemAdr  out  32  drain address (head entry, bits [1:0]=0).
REQ-013 Port: MemWData  out  32  drain data (head entry).
REQ-014 Port: MemReady  in  1  memory accepts the drain at this rising edge.
REQ-015 Port: MemRAdr  out  32  load address to memory, equal to DataAdr.
REQ-016 Port: MemRData  in  32  memory combinational read data.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries {word address [31:2], data [31:0]} with head pointer, tail pointer and count (0..DEPTH).
REQ-018 MemWe SHALL equal (count != 0); MemAdr/MemWData SHALL present the head entry; with count = 0, both SHALL be 0.
REQ-019 A drain SHALL occur at a rising edge where MemWe=1 and MemReady=1: head advances (modulo DEPTH), count decrements.
REQ-020 Coalesce: when MemWrite=1, count != 0, DataAdr[31:2] equals the youngest entry's address, and that entry is not being drained this cycle (not (count=1 and drain)), the youngest entry's data SHALL be overwritten; no allocation, count unchanged by the store.
REQ-021 Allocate: when MemWrite=1, no coalesce applies, and count < DEPTH, the store SHALL be written at tail, tail advances modulo DEPTH, count increments.
REQ-022 Stall SHALL equal MemWrite and (count = DEPTH) and no coalesce is possible; a drain in the same cycle SHALL NOT clear Stall (no full-cycle bypass); the stalled store is not recorded.
REQ-023 Simultaneous allocate and drain SHALL leave count unchanged; both pointers advance.
REQ-024 Latency: an accepted store SHALL be visible on MemWe/MemAdr at the next cycle at the earliest (when it becomes head); one drain per cycle maximum.
REQ-025 Forwarding: ReadData SHALL equal the data of the youngest valid entry whose address equals DataAdr[31:2]; if none, ReadData = MemRData. An entry draining this cycle still counts as valid for forwarding.
REQ-026 A store presented in the current cycle SHALL NOT forward to itself in that cycle.
REQ-027 Empty SHALL equal (count = 0).
REQ-028 Pointer wrap-around SHALL be seamless; ordering of drains SHALL equal acceptance order.
REQ-029 MemRAdr SHALL equal DataAdr unconditionally.

Reset
REQ-030 On reset at a rising edge: count=0, head=0, tail=0; all entries are discarded (no drain of pending stores); Stall=0, Empty=1, MemWe=0, MemAdr=0, MemWData=0 from the following cycle.
REQ-031 A store or MemReady coincident with reset SHALL be ignored.
REQ-032 Entry data contents need not be cleared; count alone defines validity.

Verification
REQ-033 Store 25 to addr 100, MemReady=1 -> next cycle MemWe=1, MemAdr=100, MemWData=25; following cycle Empty=1.
REQ-034 MemReady=0, stores 1..4 to addrs 0,4,8,12 -> count=4; 5th store to addr 16 -> Stall=1; raise MemReady -> drains in order 0,4,8,12; store to 16 accepted once count<4.
REQ-035 MemReady=0, store 7 to addr 96, then 9 to addr 96 -> one entry, MemWData=9; load addr 96 -> ReadData=9 while MemRData=0.
REQ-036 Stores 5 to addr 64 then 6 to addr 68 then 8 to addr 64 (non-coalescing, MemReady=0) -> load addr 64 returns 8; load addr 200 returns MemRData.
REQ-037 Fill 3 entries, assert reset one cycle -> Empty=1, MemWe=0, no drains issued afterwards.
REQ-038 Full buffer, MemWrite and MemReady both 1 -> Stall=1, one drain, count=3; next cycle store accepted, count=4.
